inst_fetch_responder: RTL and testbench

- Instruction-memory responder: the memory end of the CPU fetch interface. It accepts PC fetch requests and returns 32-bit instructions.
- Holds a word-addressed instruction ROM image. The bench/loader fills it through a load port.
- Requests use a valid/ready handshake and are served in order after a fixed pipeline latency.
- A response FIFO absorbs consumer backpressure.

---
 rtl/inst_fetch_responder_if.sv | 21 ++
 rtl/inst_fetch_responder.sv | 124 ++++++++++++
 tb/tb_inst_fetch_responder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_responder_if.sv
// Fetch-side handshake bundle between a CPU fetch unit (master) and the
// instruction memory responder (slave).
interface inst_fetch_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_inst, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_inst, rsp_err
  );
endinterface

// File: rtl/inst_fetch_responder.sv
// Instruction ROM responder: accepts PC fetches, returns words in order after a
// fixed pipeline latency, with a response FIFO absorbing consumer backpressure.
module inst_fetch_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  inst_fetch_responder_if.slave bus,
  input  logic                  ld_we_i,
  input  logic [DEPTH_LOG2-1:0] ld_addr_i,
  input  logic [31:0]           ld_data_i
);
  localparam int unsigned WORDS = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned LAST  = LATENCY - 1;

  logic [31:0] mem_q [WORDS];

  // Request-side address check and memory read
  logic [32:0]           addr_ext_c;
  logic [32:0]           lo_bound_c;
  logic [32:0]           hi_bound_c;
  logic [31:0]           offset_c;
  logic [DEPTH_LOG2-1:0] req_idx_c;
  logic                  req_err_c;
  logic [31:0]           req_data_c;
  logic                  req_fire_c;

  // Pipeline stages; stage 0 captures the acceptance-cycle read
  logic [LATENCY-1:0] pv_q;
  logic [LATENCY-1:0] pe_q;
  logic [31:0]        pd_q [LATENCY];

  // Response FIFO and outstanding tracking
  logic [31:0]      fifo_inst_q [FIFO_DEPTH];
  logic             fifo_err_q  [FIFO_DEPTH];
  logic [PTR_W:0]   wptr_q, wptr_d;
  logic [PTR_W:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty_c;
  logic             full_c;
  logic             push_c;
  logic             pop_c;

  always_ff @(posedge clk_i) begin
    if (ld_we_i) mem_q[ld_addr_i] <= ld_data_i;
  end

  assign addr_ext_c = {1'b0, bus.req_addr};
  assign lo_bound_c = {1'b0, BASE_ADDR};
  assign hi_bound_c = lo_bound_c + (33'(WORDS) << 2);
  assign offset_c   = bus.req_addr - BASE_ADDR;
  assign req_idx_c  = offset_c[DEPTH_LOG2+1:2];
  assign req_err_c  = (bus.req_addr[1:0] != 2'b00) || (addr_ext_c < lo_bound_c) ||
                      (addr_ext_c >= hi_bound_c);
  // Same-edge load leaves mem_q unchanged until after this read is captured
  assign req_data_c = req_err_c ? 32'h0 : mem_q[req_idx_c];
  assign req_fire_c = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pv_q <= '0;
      pe_q <= '0;
      for (int i = 0; i < int'(LATENCY); i++) pd_q[i] <= '0;
    end else begin
      pv_q[0] <= req_fire_c;
      pe_q[0] <= req_err_c;
      pd_q[0] <= req_data_c;
      for (int i = 1; i < int'(LATENCY); i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  assign empty_c = (wptr_q == rptr_q);
  assign full_c  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                   (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign push_c  = pv_q[LAST] && !full_c;
  assign pop_c   = !empty_c && bus.rsp_ready;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_c) wptr_d = wptr_q + (PTR_W+1)'(1);
    if (pop_c)  rptr_d = rptr_q + (PTR_W+1)'(1);
    case ({req_fire_c, pop_c})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_inst_q[i] <= '0;
        fifo_err_q[i]  <= 1'b0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (push_c) begin
        fifo_inst_q[wptr_q[PTR_W-1:0]] <= pd_q[LAST];
        fifo_err_q[wptr_q[PTR_W-1:0]]  <= pe_q[LAST];
      end
    end
  end

  assign bus.req_ready = (cnt_q < CNT_W'(FIFO_DEPTH));
  assign bus.rsp_valid = !empty_c;
  assign bus.rsp_inst  = fifo_inst_q[rptr_q[PTR_W-1:0]];
  assign bus.rsp_err   = fifo_err_q[rptr_q[PTR_W-1:0]];
endmodule

// File: tb/tb_inst_fetch_responder.sv
// Scoreboard bench for inst_fetch_responder: directed fetches push expected
// responses; a negedge monitor pops and compares every response handshake.
module tb_inst_fetch_responder;
  logic        clk;
  logic        rst_n;
  logic        ld_we;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;

  inst_fetch_responder_if bus ();

  inst_fetch_responder u_dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .bus      (bus),
    .ld_we_i  (ld_we),
    .ld_addr_i(ld_addr),
    .ld_data_i(ld_data)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cyc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   seq_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  // Monitor: every response handshake is checked against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got inst=%08h err=%0b, want no response",
                 bus.rsp_inst, bus.rsp_err);
      end else begin
        e = exp_q.pop_front();
        if (bus.rsp_inst !== e.inst || bus.rsp_err !== e.err) begin
          errors++;
          $display("FAIL rsp_data: got inst=%08h err=%0b, want inst=%08h err=%0b",
                   bus.rsp_inst, bus.rsp_err, e.inst, e.err);
        end
      end
      pop_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %08h, want %08h", name, got, want);
    end
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_we = 1'b0;
  endtask

  // Offers one request, waits for acceptance, records its expected response
  task automatic send(input logic [31:0] a, input logic [31:0] ei, input logic ee,
                      output int stalls);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    stalls = n;
    if (!bus.req_ready) begin
      checks++; errors++;
      $display("FAIL req_timeout: got req_ready=0 for addr %08h, want acceptance", a);
    end else begin
      exp_q.push_back('{inst: ei, err: ee});
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || bus.rsp_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int st;
    int tot;
    rst_n = 1'b0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.rsp_ready = 1'b1;
    #12;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_inst", bus.rsp_inst, 32'h0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);

    load(10'd0, 32'h0000_0413);
    load(10'd1, 32'h0010_0093);
    load(10'd2, 32'h0020_8133);
    load(10'd3, 32'h0010_0073);
    load(10'd1023, 32'h1234_5678);

    // Single fetch latency: visible only after the second edge past acceptance
    send(32'h8000_0000, 32'h0000_0413, 1'b0, st);
    @(negedge clk); check("lat_t0", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk); check("lat_t1", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk); check("lat_t2", 32'(bus.rsp_valid), 32'd1);
    drain("single");

    // Back-to-back fetches
    pop_cyc_q.delete();
    tot = 0;
    send(32'h8000_0000, 32'h0000_0413, 1'b0, st); tot += st;
    send(32'h8000_0004, 32'h0010_0093, 1'b0, st); tot += st;
    send(32'h8000_0008, 32'h0020_8133, 1'b0, st); tot += st;
    send(32'h8000_000C, 32'h0010_0073, 1'b0, st); tot += st;
    drain("b2b");
    check("b2b_stalls", 32'(tot), 32'd0);
    check("b2b_count", 32'(pop_cyc_q.size()), 32'd4);
    if (pop_cyc_q.size() == 4) begin
      for (int i = 0; i < 3; i++)
        check("b2b_gap", 32'(pop_cyc_q[i+1] - pop_cyc_q[i]), 32'd1);
    end

    // Backpressure: four accepted, fifth held
    bus.rsp_ready = 1'b0;
    seq_done = 1'b0;
    fork
      begin
        int s;
        send(32'h8000_0000, 32'h0000_0413, 1'b0, s);
        send(32'h8000_0004, 32'h0010_0093, 1'b0, s);
        send(32'h8000_0008, 32'h0020_8133, 1'b0, s);
        send(32'h8000_000C, 32'h0010_0073, 1'b0, s);
        send(32'h8000_0000, 32'h0000_0413, 1'b0, s);
        seq_done = 1'b1;
      end
    join_none
    repeat (8) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rsp_inst", bus.rsp_inst, 32'h0000_0413);
    end
    check("bp_accepted", 32'(exp_q.size()), 32'd4);
    check("bp_held", 32'(bus.req_valid), 32'd1);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 200 && !seq_done; n++) @(posedge clk);
    check("bp_seq_done", 32'(seq_done), 32'd1);
    #1;
    drain("bp");
    check("bp_outstanding", 32'(u_dut.cnt_q), 32'd0);

    // Address errors and top-of-range word
    send(32'h8000_0002, 32'h0, 1'b1, st);
    send(32'h7FFF_FFFC, 32'h0, 1'b1, st);
    send(32'h8000_1000, 32'h0, 1'b1, st);
    send(32'h8000_0FFC, 32'h1234_5678, 1'b0, st);
    drain("err");

    // Same-edge load and fetch returns old data
    ld_we = 1'b1; ld_addr = 10'd1; ld_data = 32'hDEAD_BEEF;
    send(32'h8000_0004, 32'h0010_0093, 1'b0, st);
    ld_we = 1'b0;
    send(32'h8000_0004, 32'hDEAD_BEEF, 1'b0, st);
    drain("ldfetch");

    // Reset mid-operation
    bus.rsp_ready = 1'b0;
    send(32'h8000_0000, 32'h0000_0413, 1'b0, st);
    send(32'h8000_0008, 32'h0020_8133, 1'b0, st);
    send(32'h8000_000C, 32'h0010_0073, 1'b0, st);
    repeat (3) @(posedge clk);
    #3;
    check("mid_rsp_valid_pre", 32'(bus.rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rsp_valid_rst", 32'(bus.rsp_valid), 32'd0);
    exp_q.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    send(32'h8000_0000, 32'h0000_0413, 1'b0, st);
    drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
